// File: rtl/dec_accum_if.sv
// Sample-stream bus between the producer and dec_accum, plus the averaged
// output that feeds the downstream register's data / write-enable pins.
// Phase_DO is kept 1 bit wide (tied to 0) when DEC_LOG2 = 0 so the bus
// never has a zero-width field.
interface dec_accum_if #(
  parameter int DATA_WIDTH = 10,
  parameter int DEC_LOG2   = 2
);
  localparam int PH_W = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;

  logic                          Clear_SI;
  logic                          Valid_SI;
  logic signed [DATA_WIDTH-1:0]  D_DI;
  logic signed [DATA_WIDTH-1:0]  D_DO;
  logic                          WrEn_SO;
  logic        [PH_W-1:0]        Phase_DO;

  // producer side: drives samples, observes the averaged result
  modport master (
    output Clear_SI, Valid_SI, D_DI,
    input  D_DO, WrEn_SO, Phase_DO
  );

  // dec_accum side
  modport slave (
    input  Clear_SI, Valid_SI, D_DI,
    output D_DO, WrEn_SO, Phase_DO
  );
endinterface

// File: rtl/dec_accum.sv
// Decimating accumulate-and-average stage. Sums N = 2^DEC_LOG2 valid signed
// samples, divides by N with an arithmetic shift and presents the result
// with a one-cycle write-enable strobe, one cycle after the Nth sample.
// Optional build macro: DEC_ACCUM_ROUND_EN -- round half up instead of floor.
module dec_accum #(
  parameter int DATA_WIDTH = 10,
  parameter int DEC_LOG2   = 2
) (
  input  logic         Clk_CI,
  input  logic         Rst_RBI,
  dec_accum_if.slave   bus
);
  localparam int ACC_WIDTH = DATA_WIDTH + DEC_LOG2;
  localparam int N         = 1 << DEC_LOG2;
  localparam int CW        = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
`ifdef DEC_ACCUM_ROUND_EN
  localparam int RND_INC   = (DEC_LOG2 > 0) ? (1 << (DEC_LOG2 - 1)) : 0;
`else
  localparam int RND_INC   = 0;
`endif

  logic        [CW-1:0]         cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                         wren_q, wren_d;

  logic signed [ACC_WIDTH-1:0]  sample_ext;
  logic signed [ACC_WIDTH-1:0]  base;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic signed [ACC_WIDTH-1:0]  sum_r;
  logic                         last;
  logic                         unused_sum;

  // Width of ACC_WIDTH guarantees N full-scale samples (plus the rounding
  // increment) never overflow, so no saturation logic is needed.
  assign sample_ext = ACC_WIDTH'(bus.D_DI);
  assign last       = (cnt_q == CW'(N - 1));
  assign base       = (cnt_q == '0) ? '0 : acc_q;
  assign sum        = base + sample_ext;
  assign sum_r      = sum + ACC_WIDTH'(RND_INC);
  // only the upper DATA_WIDTH bits of the rounded sum reach the output
  assign unused_sum = ^sum_r;

  // next-state: clear beats valid; completing sample loads output and strobes
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    dout_d = dout_q;
    wren_d = 1'b0;
    if (bus.Clear_SI) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (bus.Valid_SI) begin
      acc_d = sum;
      if (last) begin
        cnt_d  = '0;
        dout_d = sum_r[DEC_LOG2 +: DATA_WIDTH];
        wren_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      dout_q <= '0;
      wren_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      dout_q <= dout_d;
      wren_q <= wren_d;
    end
  end

  assign bus.D_DO     = dout_q;
  assign bus.WrEn_SO  = wren_q;
  assign bus.Phase_DO = cnt_q;
endmodule

// File: tb/tb_dec_accum.sv
// Bench for dec_accum: table of directed steps with per-step expected
// Phase/WrEn/D_DO, plus a queue scoreboard fed by an integer-division model
// that checks every strobe (directed and random phases).
module tb_dec_accum;
  localparam int DW = 10;
  localparam int DL = 2;
  localparam int N  = 1 << DL;
`ifdef DEC_ACCUM_ROUND_EN
  localparam int EXP_NEG = -1;
`else
  localparam int EXP_NEG = -2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dec_accum_if #(.DATA_WIDTH(DW), .DEC_LOG2(DL)) bus ();
  dec_accum #(.DATA_WIDTH(DW), .DEC_LOG2(DL)) dut (
    .Clk_CI (clk),
    .Rst_RBI(rst_n),
    .bus    (bus)
  );

  typedef struct {
    bit rst; bit clr; bit vld; int d;
    int ph; bit wr; int dout;
  } vec_t;

  vec_t tv[$];
  int   sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_cnt = 0;
  int   m_acc = 0;

  // average as integer floor division (optionally round half up)
  function automatic int avg(input int s);
    int q;
`ifdef DEC_ACCUM_ROUND_EN
    s = s + N / 2;
`endif
    q = s / N;
    if ((s % N) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic void add(input bit rst, input bit clr, input bit vld,
                              input int d, input int ph, input bit wr,
                              input int dout);
    vec_t v;
    v.rst = rst; v.clr = clr; v.vld = vld; v.d = d;
    v.ph = ph; v.wr = wr; v.dout = dout;
    tv.push_back(v);
  endfunction

  // drive one cycle, update model, then check the scoreboard after the edge
  task automatic step(input bit rst, input bit clr, input bit vld, input int d);
    int exp;
    rst_n        = ~rst;
    bus.Clear_SI = clr;
    bus.Valid_SI = vld;
    bus.D_DI     = DW'(d);
    if (rst) begin
      m_cnt = 0; m_acc = 0;
    end else if (clr) begin
      m_cnt = 0; m_acc = 0;
    end else if (vld) begin
      m_acc = (m_cnt == 0) ? d : m_acc + d;
      if (m_cnt == N - 1) begin
        sb.push_back(avg(m_acc));
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    if (bus.WrEn_SO) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_spurious_strobe: got WrEn_SO=1 D_DO=%0d, expected no strobe",
                 $signed(bus.D_DO));
      end else begin
        exp = sb.pop_front();
        if ($signed(bus.D_DO) != exp) begin
          n_err++;
          $display("FAIL sb_dout: got %0d, expected %0d", $signed(bus.D_DO), exp);
        end
      end
    end else if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_missing_strobe: got WrEn_SO=0, expected strobe with %0d",
               sb.pop_front());
    end
  endtask

  initial begin
    rst_n = 1'b0; bus.Clear_SI = 1'b0; bus.Valid_SI = 1'b0; bus.D_DI = '0;

    //   rst clr vld  d     ph wr dout
    add(1, 0, 0,    0,     0, 0, 0);     // reset state
    add(1, 0, 1,  300,     0, 0, 0);     // reset overrides valid
    // basic frame 10,20,30,40 -> 25
    add(0, 0, 1,   10,     1, 0, 0);
    add(0, 0, 1,   20,     2, 0, 0);
    add(0, 0, 1,   30,     3, 0, 0);
    add(0, 0, 1,   40,     0, 1, 25);
    add(0, 0, 0,    0,     0, 0, 25);    // strobe is one cycle only
    // negative floor / round
    add(0, 0, 1,   -1,     1, 0, 25);
    add(0, 0, 1,   -1,     2, 0, 25);
    add(0, 0, 1,   -1,     3, 0, 25);
    add(0, 0, 1,   -2,     0, 1, EXP_NEG);
    add(0, 0, 0,    0,     0, 0, EXP_NEG);
    // full-scale frames back to back
    add(0, 0, 1,  511,     1, 0, EXP_NEG);
    add(0, 0, 1,  511,     2, 0, EXP_NEG);
    add(0, 0, 1,  511,     3, 0, EXP_NEG);
    add(0, 0, 1,  511,     0, 1, 511);
    add(0, 0, 1, -512,     1, 0, 511);
    add(0, 0, 1, -512,     2, 0, 511);
    add(0, 0, 1, -512,     3, 0, 511);
    add(0, 0, 1, -512,     0, 1, -512);
    add(0, 0, 0,    0,     0, 0, -512);
    // gaps between samples
    add(0, 0, 1,    8,     1, 0, -512);
    add(0, 0, 0,  123,     1, 0, -512);
    add(0, 0, 0,  -99,     1, 0, -512);
    add(0, 0, 1,    8,     2, 0, -512);
    add(0, 0, 0,    0,     2, 0, -512);
    add(0, 0, 1,    8,     3, 0, -512);
    add(0, 0, 1,    8,     0, 1, 8);
    add(0, 0, 0,    0,     0, 0, 8);
    // clear drops partial frame and the simultaneous sample
    add(0, 0, 1,  100,     1, 0, 8);
    add(0, 0, 1,  100,     2, 0, 8);
    add(0, 1, 1,  100,     0, 0, 8);
    add(0, 0, 1,    4,     1, 0, 8);
    add(0, 0, 1,    4,     2, 0, 8);
    add(0, 0, 1,    4,     3, 0, 8);
    add(0, 0, 1,    4,     0, 1, 4);
    add(0, 0, 0,    0,     0, 0, 4);
    // clear on completion cycle suppresses strobe and update
    add(0, 0, 1,   60,     1, 0, 4);
    add(0, 0, 1,   60,     2, 0, 4);
    add(0, 0, 1,   60,     3, 0, 4);
    add(0, 1, 1,   60,     0, 0, 4);
    // reset mid-frame
    add(0, 0, 1,   10,     1, 0, 4);
    add(0, 0, 1,   20,     2, 0, 4);
    add(0, 0, 1,   30,     3, 0, 4);
    add(0, 0, 1,   40,     0, 1, 25);
    add(0, 0, 1,   50,     1, 0, 25);
    add(0, 0, 1,   50,     2, 0, 25);
    add(0, 0, 1,   50,     3, 0, 25);
    add(1, 0, 0,    0,     0, 0, 0);
    add(0, 0, 1,    1,     1, 0, 0);
    add(0, 0, 1,    1,     2, 0, 0);
    add(0, 0, 1,    1,     3, 0, 0);
    add(0, 0, 1,    1,     0, 1, 1);
    add(0, 0, 0,    0,     0, 0, 1);

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].rst, tv[i].clr, tv[i].vld, tv[i].d);
      n_vec++;
      if (int'(bus.Phase_DO) != tv[i].ph || bus.WrEn_SO != tv[i].wr ||
          $signed(bus.D_DO) != tv[i].dout) begin
        n_err++;
        $display("FAIL vec%0d: got ph=%0d wr=%0b dout=%0d, expected ph=%0d wr=%0b dout=%0d",
                 i, bus.Phase_DO, bus.WrEn_SO, $signed(bus.D_DO),
                 tv[i].ph, tv[i].wr, tv[i].dout);
      end
    end

    // random traffic, checked by the scoreboard and a phase model
    for (int i = 0; i < 400; i++) begin
      step(1'b0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 1023)) - 512);
      n_vec++;
      if (int'(bus.Phase_DO) != m_cnt) begin
        n_err++;
        $display("FAIL rnd_phase%0d: got %0d, expected %0d", i, bus.Phase_DO, m_cnt);
      end
    end
    step(1'b0, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
